lm_event_queue: RTL and testbench

Buffered event presenter that sits directly upstream of the LED manager. It captures single-cycle data/error codes from the UART and CM producers into a small FIFO. It then replays them one at a time on a valid/data pair, holding each code long enough to be visible on the board LEDs. A blanking gap separates consecutive identical codes. One instance is used per LED-manager input channel: UART data, UART errors and CM errors.

---
 rtl/lm_event_queue_pkg.sv | 23 ++
 rtl/lm_sync_fifo.sv | 56 +++++
 rtl/lm_event_queue.sv | 108 ++++++++++
 tb/tb_lm_event_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lm_event_queue_pkg.sv
// Shared constants for the LED-manager event queue.
//   LM_HOLD_CYCLES_DEF / LM_GAP_CYCLES_DEF : default presentation and blanking times
//   lm_state_e                              : presenter FSM encoding
//   lm_cnt_width()                          : hold/gap counter width
package lm_event_queue_pkg;

  localparam int unsigned LM_HOLD_CYCLES_DEF = 25_000_000;
  localparam int unsigned LM_GAP_CYCLES_DEF  = 2_500_000;

  typedef enum logic [1:0] {
    LM_IDLE = 2'd0,
    LM_SHOW = 2'd1,
    LM_GAP  = 2'd2
  } lm_state_e;

  // Wide enough to hold max(hold, gap) - 1; never narrower than one bit.
  function automatic int unsigned lm_cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = (hold > gap) ? hold : gap;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lm_sync_fifo.sv
// Small synchronous FIFO with single-cycle push/pop.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/pop   : write / read strobes (pop ignored when empty)
//   wr_data    : data written on push
//   head       : entry at the read pointer
//   full/empty : occupancy flags
//   level      : occupancy count
// A push while full is accepted only if a pop happens in the same cycle.
module lm_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/lm_event_queue.sv
// Buffered event presenter feeding one LED-manager channel.
// Single-cycle codes are queued, then each is shown for HOLD_CYCLES with
// rd_valid high, followed by GAP_CYCLES of blank output and one IDLE cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_data    : code from producer, captured when wr_valid is high
//   wr_valid   : single-cycle write strobe
//   ovf_clr    : clears the sticky overflow flag (a simultaneous set wins)
//   rd_data    : code being presented, zero when rd_valid is low
//   rd_valid   : high for the whole hold window
//   overflow   : sticky, set when a write is dropped on a full queue
//   level      : queue occupancy
module lm_event_queue
  import lm_event_queue_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned HOLD_CYCLES = LM_HOLD_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES  = LM_GAP_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_valid,
  input  logic                   ovf_clr,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned CW        = lm_cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);

  lm_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;
  logic             drop;

  lm_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_valid),
    .pop     (pop),
    .wr_data (wr_data),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // A write on a full queue survives only when IDLE pops in the same cycle.
  assign drop = wr_valid && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      LM_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = LM_SHOW;
        end
      end
      LM_SHOW: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = LM_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      LM_GAP: begin
        if (cnt_q == '0) state_d = LM_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = LM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LM_IDLE;
      cnt_q    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      // Outputs are registered from the next state so they line up with it.
      rd_valid <= (state_d == LM_SHOW);
      if (pop)                     rd_data <= head;
      else if (state_d != LM_SHOW) rd_data <= '0;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lm_event_queue.sv
// Scoreboard bench for lm_event_queue (WIDTH=8, DEPTH=4, HOLD=4, GAP=2).
module tb_lm_event_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       overflow;
  logic [2:0] level;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  logic [7:0]  sb[$];

  always #5 clk = ~clk;

  lm_event_queue #(
    .WIDTH       (8),
    .DEPTH       (4),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .ovf_clr  (ovf_clr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .overflow (overflow),
    .level    (level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] c, input bit acc);
    wr_data  = c;
    wr_valid = 1'b1;
    if (acc) sb.push_back(c);
    tick();
    wr_valid = 1'b0;
    wr_data  = '0;
  endtask

  // Expected waveform relative to the cycle of the first write (offset 0):
  // code j shows at offsets 2+7j .. 5+7j, blank otherwise.
  task automatic pattern(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input int n, input int k0, input int lvl0_from);
    logic [7:0] codes [3];
    codes = '{c0, c1, c2};
    for (int k = k0; k <= 7*n + 1; k++) begin
      int j;
      int ph;
      logic evv;
      logic [7:0] ev;
      j   = (k >= 2) ? (k - 2) / 7 : 0;
      ph  = (k >= 2) ? (k - 2) % 7 : 0;
      evv = (k >= 2) && (j < n) && (ph < 4);
      ev  = evv ? codes[j] : 8'h00;
      chk("pattern rd_valid", 32'(rd_valid), 32'(evv));
      chk("pattern rd_data", 32'(rd_data), 32'(ev));
      if (k >= lvl0_from) chk("pattern level", 32'(level), 32'd0);
      tick();
    end
  endtask

  task automatic drain(input string name);
    int unsigned i;
    i = 0;
    while ((level != 0 || rd_valid || sb.size() != 0) && i < 300) begin
      tick();
      i++;
    end
    repeat (8) tick();
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each presentation and checks shape.
  logic       prev_v   = 1'b0;
  logic       seen_any = 1'b0;
  int         run_len  = 0;
  int         low_len  = 0;
  logic [7:0] cur      = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v   = 1'b0;
      seen_any = 1'b0;
      run_len  = 0;
      low_len  = 0;
    end else if (rd_valid) begin
      if (!prev_v) begin
        if (sb.size() == 0) begin
          chk("unexpected presentation", 32'(rd_data), 32'hFFFF_FFFF);
          cur = rd_data;
        end else begin
          cur = sb.pop_front();
          chk("presented code", 32'(rd_data), 32'(cur));
        end
        if (seen_any) chk("gap >= GAP+1", 32'(low_len >= 3), 32'd1);
        seen_any = 1'b1;
        run_len  = 1;
      end else begin
        run_len++;
        chk("code stable while held", 32'(rd_data), 32'(cur));
      end
      prev_v = 1'b1;
    end else begin
      if (prev_v) begin
        chk("hold length", 32'(run_len), 32'd4);
        low_len = 0;
      end
      low_len++;
      chk("rd_data zero when idle", 32'(rd_data), 32'd0);
      prev_v = 1'b0;
    end
  end

  initial begin
    // Reset held: writes ignored, outputs zero.
    repeat (2) tick();
    wr(8'hAA, 1'b0);
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post-reset level", 32'(level), 32'd0);
    chk("post-reset rd_valid", 32'(rd_valid), 32'd0);

    // Single code.
    wr(8'h5A, 1'b1);
    chk("single level", 32'(level), 32'd1);
    pattern(8'h5A, 8'h00, 8'h00, 1, 1, 3);
    repeat (3) tick();

    // Burst of three distinct codes.
    wr(8'h01, 1'b1);
    wr(8'h02, 1'b1);
    wr(8'h03, 1'b1);
    pattern(8'h01, 8'h02, 8'h03, 3, 3, 99);
    repeat (3) tick();

    // Identical codes are separated by a blank gap.
    wr(8'h07, 1'b1);
    wr(8'h07, 1'b1);
    pattern(8'h07, 8'h07, 8'h00, 2, 2, 99);
    repeat (3) tick();

    // Overflow: 0x11 shows at t+2..t+5, four queued -> full at t+5.
    wr(8'h11, 1'b1);
    wr(8'h12, 1'b1);
    wr(8'h13, 1'b1);
    wr(8'h14, 1'b1);
    wr(8'h15, 1'b1);
    chk("full level", 32'(level), 32'd4);
    chk("no overflow yet", 32'(overflow), 32'd0);
    wr(8'hFF, 1'b0);
    chk("overflow set", 32'(overflow), 32'd1);
    chk("drop keeps level", 32'(level), 32'd4);
    ovf_clr = 1'b1;
    wr(8'hFE, 1'b0);
    ovf_clr = 1'b0;
    chk("set wins over clear", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("overflow cleared", 32'(overflow), 32'd0);
    chk("full before pop", 32'(level), 32'd4);
    // This cycle is IDLE with the queue full: the write rides on the pop.
    wr(8'h16, 1'b1);
    chk("push on pop level", 32'(level), 32'd4);
    chk("push on pop no overflow", 32'(overflow), 32'd0);
    drain("overflow drain");

    // Pointer wrap: ten codes spaced one presentation period apart.
    for (int i = 0; i < 10; i++) begin
      wr(8'h30 + 8'(i), 1'b1);
      chk("wrap level <= 3", 32'(level <= 3), 32'd1);
      repeat (6) tick();
    end
    drain("wrap drain");

    // Reset during SHOW with two codes queued.
    wr(8'h41, 1'b1);
    wr(8'h42, 1'b1);
    wr(8'h43, 1'b1);
    chk("pre-reset rd_valid", 32'(rd_valid), 32'd1);
    chk("pre-reset level", 32'(level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset rd_valid", 32'(rd_valid), 32'd0);
    chk("mid reset rd_data", 32'(rd_data), 32'd0);
    chk("mid reset level", 32'(level), 32'd0);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    chk("after reset level", 32'(level), 32'd0);
    chk("after reset rd_valid", 32'(rd_valid), 32'd0);
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
